// File: rtl/mul_pkg.sv
// Shared constants, default stage payload layout and the output clamp used by pipelined_fx_multiplier.
package mul_pkg;
  localparam int DEF_A_W       = 32;
  localparam int DEF_B_W       = 32;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_LAT       = 4;
  localparam int DEF_TAG_W     = 8;
  // Working width of the clamp; must exceed A_W+B_W+2 of any instance.
  localparam int SAT_W         = 128;

  typedef struct packed {
    logic [DEF_A_W+DEF_B_W-1:0] product;
    logic [DEF_TAG_W-1:0]       tag;
  } stage_payload_t;

  // Returns {ovf, value}; value is r clamped to the OUT_W range of the chosen signedness.
  function automatic logic [SAT_W:0] sat_clamp(input logic signed [SAT_W-1:0] r,
                                               input int out_w, input logic sgn);
    logic signed [SAT_W-1:0] one, hi, lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    if (sgn) begin
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
    end else begin
      hi = (one <<< out_w) - one;
      lo = '0;
    end
    if (r > hi)      sat_clamp = {1'b1, hi};
    else if (r < lo) sat_clamp = {1'b1, lo};
    else             sat_clamp = {1'b0, r};
  endfunction
endpackage

// File: rtl/mul_pipe_stage.sv
// One elastic pipeline register: valid + payload, loads whenever empty or draining downstream.
module mul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  assign in_rdy = !vld_q || out_rdy;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_rdy) begin
      vld_d = in_vld;
      // Payload only moves with a valid item so outputs hold during bubbles.
      if (in_vld) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;
endmodule

// File: rtl/pipelined_fx_multiplier.sv
// Fixed-point multiplier with elastic LAT-stage pipeline, Q rescale and saturation.
// Optional MUL_ROUND_EN: round-half-up before the rescale shift instead of truncating.
module pipelined_fx_multiplier
  import mul_pkg::*;
#(
  parameter int A_W       = DEF_A_W,
  parameter int B_W       = DEF_B_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int LAT       = DEF_LAT,
  parameter int SIGNED    = 1,
  parameter int TAG_W     = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf
);
  localparam int PW = A_W + B_W;
  localparam int MW = PW + TAG_W;
  localparam int LW = 1 + OUT_W + TAG_W;

  logic [LAT:0]             vld_pipe;
  logic [LAT+1:1]           rdy_pipe;
  logic [LAT-1:1][MW-1:0]   mid_q;
  logic [LW-1:0]            last_d, last_q;

  logic [PW-1:0]            a_x, b_x, prod;
  logic [PW-1:0]            p_full;
  logic [TAG_W-1:0]         tag_last;
  logic [PW+1:0]            p_ext, p_rnd;
  logic signed [PW+1:0]     r_sh;
  logic [SAT_W-1:0]         r_w;
  logic [SAT_W:0]           sat;
  logic                     sat_unused;

  // Operands extended to the product width so one unsigned multiply serves both modes.
  always_comb begin
    a_x  = (SIGNED != 0) ? {{B_W{a[A_W-1]}}, a} : {{B_W{1'b0}}, a};
    b_x  = (SIGNED != 0) ? {{A_W{b[B_W-1]}}, b} : {{A_W{1'b0}}, b};
    prod = a_x * b_x;
  end

`ifdef MUL_ROUND_EN
  localparam int            RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [PW+1:0] RND = (FRAC_BITS > 0) ? ({{(PW+1){1'b0}}, 1'b1} << RSH) : '0;
`endif

  // Two guard bits keep the rounding add from flipping the sign of the extended value.
  always_comb begin
    p_full   = mid_q[LAT-1][MW-1:TAG_W];
    tag_last = mid_q[LAT-1][TAG_W-1:0];
    p_ext    = {{2{(SIGNED != 0) & p_full[PW-1]}}, p_full};
`ifdef MUL_ROUND_EN
    p_rnd    = p_ext + RND;
`else
    p_rnd    = p_ext;
`endif
    r_sh     = $signed(p_rnd) >>> FRAC_BITS;
    r_w      = {{(SAT_W-PW-2){r_sh[PW+1]}}, r_sh};
    sat      = sat_clamp(r_w, OUT_W, SIGNED != 0);
    last_d   = {sat[SAT_W], sat[OUT_W-1:0], tag_last};
  end

  assign sat_unused = ^sat[SAT_W-1:OUT_W];

  assign vld_pipe[0]        = in_valid;
  assign rdy_pipe[LAT+1]    = out_ready;
  assign in_ready           = rdy_pipe[1];
  assign out_valid          = vld_pipe[LAT];
  assign {ovf, p, out_tag}  = last_q;

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    if (k < LAT) begin : g_mid
      logic [MW-1:0] d;
      if (k == 1) begin : g_first
        assign d = {prod, in_tag};
      end else begin : g_retime
        assign d = mid_q[k-1];
      end
      mul_pipe_stage #(.W(MW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (vld_pipe[k-1]),
        .in_data  (d),
        .in_rdy   (rdy_pipe[k]),
        .out_rdy  (rdy_pipe[k+1]),
        .out_vld  (vld_pipe[k]),
        .out_data (mid_q[k])
      );
    end else begin : g_last
      mul_pipe_stage #(.W(LW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (vld_pipe[k-1]),
        .in_data  (last_d),
        .in_rdy   (rdy_pipe[k]),
        .out_rdy  (rdy_pipe[k+1]),
        .out_vld  (vld_pipe[k]),
        .out_data (last_q)
      );
    end
  end
endmodule
